// File: rtl/pic_pkg.sv
// Shared definitions for the in-service register block: FSM state type,
// level width and the level reported for a withdrawn (spurious) request.
package pic_pkg;

  localparam int unsigned LVL_W = 3;

  localparam logic [LVL_W-1:0] SPURIOUS_LEVEL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK1,
    ST_WAIT2,
    ST_ACK2
  } isr_state_e;

endpackage

// File: rtl/isr_prio_enc.sv
// Lowest-set-bit encoder over an 8-bit vector. Index 0 is the highest
// priority level, so the lowest set bit is the highest level in service.
module isr_prio_enc
  import pic_pkg::*;
(
  input  logic [7:0]       bits_i,
  output logic [LVL_W-1:0] idx_o,
  output logic             any_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx_o = '0;
    any_o = |bits_i;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bits_i[7 - i]) idx_o = LVL_W'(7 - i);
    end
  end

endmodule

// File: rtl/in_service_register.sv
// In-service register and INTA sequencer: raises INT for a nested-priority
// candidate, marks the level in service on the first INTA, presents the
// vector on the second INTA and handles specific, non-specific and
// automatic end-of-interrupt.
module in_service_register
  import pic_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       irr,
  input  logic [7:0]       imr,
  input  logic [LVL_W-1:0] chosen_interrupt,
  input  logic             inta_n,
  input  logic             eoi,
  input  logic             eoi_specific,
  input  logic [LVL_W-1:0] eoi_level,
  input  logic             aeoi,
  input  logic [4:0]       vector_base,
  output logic             int_out,
  output logic [7:0]       isr,
  output logic [7:0]       clear_irr,
  output logic             clear,
  output logic [7:0]       vector_out,
  output logic             vector_oe
);

  isr_state_e       state_q;
  logic             inta_q;
  logic [LVL_W-1:0] lvl_q;
  logic             spur_q;
  logic [7:0]       isr_q, isr_d;
  logic [7:0]       clear_irr_q;
  logic             clear_q;
  logic [7:0]       vector_out_q;
  logic             vector_oe_q;

  logic             inta_fall, inta_rise;
  logic [LVL_W-1:0] isr_low;
  logic             isr_any;
  logic             candidate;
  logic             accept;
  logic [7:0]       set_mask, eoi_mask, aeoi_mask;

  isr_prio_enc u_prio_enc (
    .bits_i (isr_q),
    .idx_o  (isr_low),
    .any_o  (isr_any)
  );

  assign inta_fall = inta_q & ~inta_n;
  assign inta_rise = ~inta_q & inta_n;

  // INT request: only from IDLE, and only for a level above everything in service.
  always_comb begin
    candidate = irr[chosen_interrupt] & ~imr[chosen_interrupt];
    int_out   = (state_q == ST_IDLE) && candidate &&
                (!isr_any || (chosen_interrupt < isr_low));
  end

  // ISR update: EOI and AEOI clears use the pre-update value; a same-cycle set wins.
  always_comb begin
    accept    = (state_q == ST_IDLE) && inta_fall && int_out;
    set_mask  = '0;
    eoi_mask  = '0;
    aeoi_mask = '0;
    if (accept) set_mask[chosen_interrupt] = 1'b1;
    if (eoi) begin
      if (eoi_specific)  eoi_mask[eoi_level] = 1'b1;
      else if (isr_any)  eoi_mask[isr_low]   = 1'b1;
    end
    if ((state_q == ST_ACK2) && inta_rise && aeoi && !spur_q) aeoi_mask[lvl_q] = 1'b1;
    isr_d = (isr_q & ~eoi_mask & ~aeoi_mask) | set_mask;
  end

  // INTA sequencer with registered ISR, pulse and vector outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      inta_q       <= 1'b1;
      lvl_q        <= '0;
      spur_q       <= 1'b0;
      isr_q        <= '0;
      clear_irr_q  <= '0;
      clear_q      <= 1'b0;
      vector_out_q <= '0;
      vector_oe_q  <= 1'b0;
    end else begin
      inta_q      <= inta_n;
      isr_q       <= isr_d;
      clear_irr_q <= set_mask;
      clear_q     <= accept;
      unique case (state_q)
        ST_IDLE: begin
          if (inta_fall) begin
            state_q <= ST_ACK1;
            lvl_q   <= accept ? chosen_interrupt : SPURIOUS_LEVEL;
            spur_q  <= !accept;
          end
        end
        ST_ACK1: begin
          if (inta_rise) state_q <= ST_WAIT2;
        end
        ST_WAIT2: begin
          if (inta_fall) begin
            state_q      <= ST_ACK2;
            vector_oe_q  <= 1'b1;
            vector_out_q <= {vector_base, lvl_q};
          end
        end
        ST_ACK2: begin
          if (inta_rise) begin
            state_q      <= ST_IDLE;
            vector_oe_q  <= 1'b0;
            vector_out_q <= '0;
          end else begin
            vector_out_q <= {vector_base, lvl_q};
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign isr        = isr_q;
  assign clear_irr  = clear_irr_q;
  assign clear      = clear_q;
  assign vector_out = vector_out_q;
  assign vector_oe  = vector_oe_q;

endmodule

// File: doc/in_service_register.md
IN_SERVICE_REGISTER -- requirements
Module: in_service_register

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-003 irr  in  8  pending request bits from the interrupt request register.
REQ-004 imr  in  8  mask bits; 1 = level masked.
REQ-005 chosen_interrupt  in  3  winning level from the priority resolver.
REQ-006 inta_n  in  1  CPU interrupt-acknowledge, active-low, synchronous to clk.
REQ-007 eoi  in  1  one-cycle end-of-interrupt command strobe.
REQ-008 eoi_specific  in  1  1 = specific EOI, 0 = non-specific; qualified by eoi.
REQ-009 eoi_level  in  3  level cleared by a specific EOI.
REQ-010 aeoi  in  1  automatic-EOI mode enable.
REQ-011 vector_base  in  5  upper five vector bits (T7..T3).
REQ-012 int_out  out  1  INT request to CPU.
REQ-013 isr  out  8  in-service bits.
REQ-014 clear_irr  out  8  one-hot, one-cycle clear pulse to the IRR.
REQ-015 clear  out  1  one-cycle pulse to the priority resolver when a level enters service.
REQ-016 vector_out  out  8  interrupt vector {vector_base, level}.
REQ-017 vector_oe  out  1  vector_out valid and driven.

Function
REQ-018 Define candidate as irr[chosen_interrupt] & ~imr[chosen_interrupt].
- int_out SHALL be 1 in IDLE when the candidate is valid and chosen_interrupt < the lowest set isr index, or isr == 0 (fully nested).
- int_out SHALL be 0 in all other states.
REQ-019 Register inta_n once into inta_q and detect edges against it.
- Falling edge: inta_q==1 & inta_n==0.
- Rising edge: inta_q==0 & inta_n==1.
REQ-020 FSM states: IDLE, ACK1, WAIT2, ACK2.
REQ-021 IDLE, falling edge with int_out==1 -> ACK1. In the same cycle:
- latch lvl = chosen_interrupt;
- set isr[lvl];
- pulse clear_irr[lvl] and clear for exactly one cycle.
REQ-022 IDLE, falling edge with int_out==0 (request withdrawn; spurious) -> ACK1.
- lvl = 7; isr unchanged; no clear_irr or clear pulse.
REQ-023 ACK1 -> WAIT2 on rising edge. WAIT2 -> ACK2 on the next falling edge.
REQ-024 In ACK2, vector_oe = 1 and vector_out = {vector_base, lvl}.
- On the rising edge in ACK2: vector_oe drops; if aeoi==1 and the sequence was not spurious, clear isr[lvl]; -> IDLE.
REQ-025 vector_oe SHALL be 0 and vector_out SHALL be 8'h00 outside ACK2.
REQ-026 Non-specific EOI clears the lowest-index set isr bit. No-op when isr==0.
REQ-027 Specific EOI clears isr[eoi_level] regardless of the other isr bits.
REQ-028 EOI is accepted in any state. It is evaluated against the isr value before this cycle's update.
- If an EOI clear and an INTA set hit the same bit in one cycle, the set wins.
REQ-029 Registered outputs (isr, clear_irr, clear, vector_out, vector_oe) are visible the cycle after the edge is detected.
REQ-030 int_out is combinational from state, isr, irr, imr and chosen_interrupt.
REQ-031 Level comparisons are 3-bit unsigned. Lower index = higher priority.

Reset
REQ-032 Reset forces: state IDLE, inta_q 1, lvl 0, isr 8'h00, clear_irr 8'h00, clear 0, vector_out 8'h00, vector_oe 0.
REQ-033 Reset overrides every concurrent event, including mid-sequence reset in ACK1, WAIT2 or ACK2; the partial sequence is abandoned.

Structure
REQ-034 Shared package pic_pkg holds:
- FSM state enum;
- SPURIOUS_LEVEL = 3'd7;
- level width constant LVL_W = 3.
REQ-035 One sub-module isr_prio_enc: 8-bit lowest-set-bit encoder (3-bit index plus any flag).
- Used for both the nesting compare and the non-specific EOI.

Verification
REQ-036 irr=8'h04, imr=0, chosen=2, base=5'h08; two INTA pulses.
- int_out=1, then isr=8'h04, clear_irr=8'h04 for one cycle, vector_out=8'h42 with vector_oe during the second INTA.
REQ-037 isr=8'h04, chosen=5, irr=8'h20 -> int_out=0.
- Then chosen=1, irr=8'h02 -> int_out=1.
REQ-038 aeoi=1, full sequence for level 3 -> isr returns to 8'h00 on the second INTA rising edge.
REQ-039 isr=8'h14, non-specific EOI -> isr=8'h10.
- Then specific EOI with eoi_level=4 -> isr=8'h00.
REQ-040 irr withdrawn before the first INTA -> isr unchanged, vector_out={base,3'd7}.
REQ-041 reset asserted while in WAIT2 -> next cycle: IDLE, isr=0, vector_oe=0.
- A new sequence then completes normally.
